uart_rx_axis: RTL and testbench

Serial UART receiver feeding the TCP/UART mux's `uart_in` AXI4-Stream slave port. It samples the asynchronous `rx` pin and deframes 8N1 characters (8E1 when parity is compiled in). Completed bytes are buffered in a small FIFO so back-pressure from the mux's polling loop does not drop characters. It also reports framing, overflow and, optionally, parity errors.

---
 rtl/uart_rx_axis.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_rx_axis.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis.sv
// -----------------------------------------------------------------------------
// uart_rx_axis
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) that pushes
// completed bytes into a small FIFO. The FIFO head is presented as an
// AXI4-Stream master. Framing, overflow and parity errors are reported as
// one-cycle pulses. A saturating counter tallies those pulses.
//
// Compile-time option:
//   UART_RX_PARITY_EN - adds an even-parity bit after the data bits and
//                       enables parity_err.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (>= 4)
//   FIFO_DEPTH    byte entries in the receive FIFO (power of 2, >= 2)
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   rx             asynchronous serial input, idles high
//   m_axis_*       AXI4-Stream master (tdata/tvalid/tready, tlast tied 0)
//   frame_err      pulse: stop bit sampled low
//   overflow       pulse: completed byte dropped, FIFO full
//   parity_err     pulse: parity mismatch (0 when parity not compiled in)
//   err_count      saturating count of error pulses
// -----------------------------------------------------------------------------
module uart_rx_axis #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       frame_err,
    output logic       overflow,
    output logic       parity_err,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Synchronizer and edge-detect history; all reset to the idle level.
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic rx_s, fall_s;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic          par_flag_q, par_flag_d;
`endif
    logic          push_s;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          empty_s, full_s, pop_s, wr_en_s;

    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic          parity_err_q, parity_err_d;
    logic [7:0]    err_count_q, err_count_d;

    assign rx_s   = rx_sync_q;
    assign fall_s = rx_prev_q & ~rx_s;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receive FSM next-state: bit timing, deframing and error detection.
    always_comb begin
        state_d      = state_q;
        timer_d      = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
`ifdef UART_RX_PARITY_EN
        par_flag_d   = par_flag_q;
`endif
        push_s       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall_s) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_flag_d = 1'b0;
`endif
                    state_d   = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                // Mid-start-bit check; a high level means a glitch, not a start.
                if (timer_q == T_HALF) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (timer_q == T_LAST) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (timer_q == T_LAST) begin
                    par_flag_d = rx_s ^ (^shift_q);
                    state_d    = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (timer_q == T_LAST) begin
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (par_flag_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            push_s = 1'b1;
                        end
`else
                        push_s = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                // A line held low must return high before a new start is armed.
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO control: a pop frees the head slot in the same cycle a full push lands.
    always_comb begin
        empty_s    = (wr_ptr_q == rd_ptr_q);
        full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s      = !empty_s && m_axis_tready;
        wr_en_s    = push_s && (!full_s || pop_s);
        overflow_d = push_s && full_s && !pop_s;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Error tally; the pulses never coincide so one increment per cycle suffices.
    always_comb begin
        if ((frame_err_d || overflow_d || parity_err_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State, datapath, FIFO and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_flag_q   <= 1'b0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_flag_q   <= par_flag_d;
`endif
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            parity_err_q <= parity_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign m_axis_tdata  = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis_tvalid = !empty_s;
    assign m_axis_tlast  = 1'b0;
    assign frame_err     = frame_err_q;
    assign overflow      = overflow_q;
    assign parity_err    = parity_err_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_axis
// Scoreboard bench for uart_rx_axis with CLKS_PER_BIT=8, FIFO_DEPTH=4.
// Expected bytes are queued as frames are driven and popped as beats appear.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_rx_axis;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       frame_err;
    logic       overflow;
    logic       parity_err;
    logic [7:0] err_count;

    int n_vec  = 0;
    int n_miss = 0;
    int frame_cnt  = 0;
    int ovf_cnt    = 0;
    int par_cnt    = 0;
    logic [7:0] exp_q [$];

    uart_rx_axis #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_err     (frame_err),
        .overflow      (overflow),
        .parity_err    (parity_err),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are sampled on
    // the falling edge, where both are stable.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_cyc(CPB);
`else
        if (par) begin
            rx = rx;
        end
`endif
        rx = stop;
        wait_cyc(CPB);
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1, ^d);
    endtask

    // Monitor: count error pulses and score every accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err)  frame_cnt++;
            if (overflow)   ovf_cnt++;
            if (parity_err) par_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {24'd0, m_axis_tdata}, 32'hFFFF_FFFF);
                end else begin
                    chk("tdata", {24'd0, m_axis_tdata}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        rx = 1'b1;
        m_axis_tready = 1'b1;
        rst_n = 1'b0;
        wait_cyc(3);
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_tdata",  {24'd0, m_axis_tdata},  32'd0);
        chk("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
        chk("rst_errs",   {29'd0, frame_err, overflow, parity_err}, 32'd0);
        chk("rst_errcnt", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(10);

        // Normal byte
        send_good(8'h04);
        wait_cyc(20);
        chk("normal_pending", exp_q.size(), 32'd0);
        chk("normal_errcnt", {24'd0, err_count}, 32'd0);

        // False start, then a good byte
        rx = 1'b0;
        wait_cyc(2);
        rx = 1'b1;
        wait_cyc(20);
        chk("false_start_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        send_good(8'hA5);
        wait_cyc(20);
        chk("after_false_pending", exp_q.size(), 32'd0);
        chk("after_false_errcnt", {24'd0, err_count}, 32'd0);

        // Framing error with a held-low line, then recovery
        b = 8'h3C;
        send_frame(b, 1'b0, ^b);
        wait_cyc(20);
        rx = 1'b1;
        wait_cyc(20);
        chk("frame_pulses", frame_cnt, 32'd1);
        chk("frame_errcnt", {24'd0, err_count}, 32'd1);
        chk("frame_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        send_good(8'h55);
        wait_cyc(20);
        chk("after_frame_pending", exp_q.size(), 32'd0);

        // Overflow: five bytes into a four-entry FIFO with no consumer
        m_axis_tready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            b = 8'(k);
            if (k <= 4) exp_q.push_back(b);
            send_frame(b, 1'b1, ^b);
        end
        wait_cyc(20);
        chk("ovf_pulses", ovf_cnt, 32'd1);
        chk("ovf_held_valid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("ovf_head", {24'd0, m_axis_tdata}, 32'h01);
        m_axis_tready = 1'b1;
        wait_cyc(10);
        chk("ovf_drain", exp_q.size(), 32'd0);
        chk("ovf_errcnt", {24'd0, err_count}, 32'd2);

`ifdef UART_RX_PARITY_EN
        // Parity: correct bit delivers the byte, wrong bit drops it
        send_frame(8'h07, 1'b1, 1'b1);
        exp_q.push_back(8'h07);
        wait_cyc(20);
        chk("par_ok_pending", exp_q.size(), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_cyc(20);
        chk("par_pulses", par_cnt, 32'd1);
        chk("par_errcnt", {24'd0, err_count}, 32'd3);
        chk("par_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
`else
        chk("par_tied_low", par_cnt, 32'd0);
`endif

        // Reset during data bit 4 of 0xFF
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_cyc(CPB);
        end
        wait_cyc(4);
        rst_n = 1'b0;
        wait_cyc(2);
        chk("rst_mid_errcnt", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(2);
        chk("rst_mid_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        wait_cyc(60);
        chk("rst_mid_no_beat", {31'd0, m_axis_tvalid}, 32'd0);
        send_good(8'h12);
        wait_cyc(20);
        chk("rst_next_pending", exp_q.size(), 32'd0);
        chk("rst_next_errcnt", {24'd0, err_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
